// File: rtl/sseg_scroll_buffer.sv
// sseg_scroll_buffer
//   Character buffer for a four-digit seven-segment display. Characters are
//   loaded one at a time. After 'go', a four-character window scrolls through
//   the stored message. The window advances one position every SCROLL_DIV
//   clocks and wraps at the end of the message.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   clear      : one-cycle request to empty the buffer and return to IDLE
//   wr_valid   : character write request
//   wr_char    : character; bit4=1 means blank, otherwise bits[3:0] hex digit
//   wr_ready   : buffer can accept a character this cycle
//   go         : one-cycle request to start scrolling (honoured in LOAD only)
//   seg3..seg0 : registered active-low segments, bit0=a .. bit6=g;
//                seg3 is the leftmost digit
//   len        : number of stored characters
//   scrolling  : high while in SCROLL
//   step       : one-cycle pulse in the cycle the window position advances
//   dbg_state  : current FSM state encoding (IDLE=0, LOAD=1, SCROLL=2)
//
// Write handshake: a character is taken on a rising edge where wr_valid and
// wr_ready are both high. wr_ready depends only on state and len, never on
// wr_valid. A clear in the same cycle wins, and no character is stored.

module sseg_scroll_buffer #(
  parameter int DEPTH      = 16,
  parameter int SCROLL_DIV = 50_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   wr_valid,
  input  logic [4:0]             wr_char,
  output logic                   wr_ready,
  input  logic                   go,
  output logic [6:0]             seg3,
  output logic [6:0]             seg2,
  output logic [6:0]             seg1,
  output logic [6:0]             seg0,
  output logic [$clog2(DEPTH):0] len,
  output logic                   scrolling,
  output logic                   step,
  output logic [1:0]             dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(SCROLL_DIV);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCROLL = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] pos_q, pos_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          step_q, step_d;
  logic [6:0]    seg_q [4];
  logic [6:0]    seg_d [4];
  logic [4:0]    buf_q [DEPTH];

  logic          wr_en;
  logic [LW-1:0] idx_c [4];
  logic [4:0]    ch_c  [4];

  function automatic logic [6:0] hex7(input logic [4:0] c);
    logic [6:0] s;
    if (c[4]) begin
      s = 7'b1111111;
    end else begin
      case (c[3:0])
        4'h0: s = 7'b1000000;
        4'h1: s = 7'b1111001;
        4'h2: s = 7'b0100100;
        4'h3: s = 7'b0110000;
        4'h4: s = 7'b0011001;
        4'h5: s = 7'b0010010;
        4'h6: s = 7'b0000010;
        4'h7: s = 7'b1111000;
        4'h8: s = 7'b0000000;
        4'h9: s = 7'b0010000;
        4'hA: s = 7'b0001000;
        4'hB: s = 7'b0000011;
        4'hC: s = 7'b1000110;
        4'hD: s = 7'b0100001;
        4'hE: s = 7'b0000110;
        default: s = 7'b0001110;
      endcase
    end
    return s;
  endfunction

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    pos_d    = pos_q;
    presc_d  = presc_q;
    step_d   = 1'b0;
    wr_en    = 1'b0;
    wr_ready = (state_q == IDLE) || ((state_q == LOAD) && (len_q < LW'(DEPTH)));

    if (clear) begin
      state_d = IDLE;
      len_d   = '0;
      pos_d   = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_valid && wr_ready) begin
            wr_en   = 1'b1;
            len_d   = LW'(1);
            state_d = LOAD;
          end
        end
        LOAD: begin
          // A write and go in the same cycle: the character is counted first.
          if (wr_valid && wr_ready) begin
            wr_en = 1'b1;
            len_d = len_q + LW'(1);
          end
          if (go) begin
            state_d = SCROLL;
            pos_d   = '0;
            presc_d = '0;
          end
        end
        SCROLL: begin
          if (presc_q == PW'(SCROLL_DIV - 1)) begin
            presc_d = '0;
            step_d  = 1'b1;
            if (({1'b0, pos_q} + LW'(1)) == len_q) begin
              pos_d = '0;
            end else begin
              pos_d = pos_q + AW'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          len_d   = '0;
          pos_d   = '0;
          presc_d = '0;
        end
      endcase
    end
  end

  // Display selection. It uses the current registered state, so the segment
  // outputs lag state, pos and buffer contents by exactly one clock.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx_c[k] = {1'b0, pos_q} + LW'(k);
      ch_c[k]  = 5'h10;
      case (state_q)
        LOAD: begin
          if (LW'(k) < len_q) begin
            ch_c[k] = buf_q[AW'(k)];
          end
        end
        SCROLL: begin
          // pos < len, so pos+k < len+3. Three conditional subtractions
          // reduce it modulo len, even when len is 1.
          for (int j = 0; j < 3; j++) begin
            if (idx_c[k] >= len_q) begin
              idx_c[k] = idx_c[k] - len_q;
            end
          end
          ch_c[k] = buf_q[idx_c[k][AW-1:0]];
        end
        default: ch_c[k] = 5'h10;
      endcase
      seg_d[k] = hex7(ch_c[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      pos_q   <= '0;
      presc_q <= '0;
      step_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        seg_q[k] <= 7'b1111111;
      end
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      for (int k = 0; k < 4; k++) begin
        seg_q[k] <= seg_d[k];
      end
    end
  end

  // The message storage is not reset. Clear and reset only drop len, and
  // entries at or beyond len are never selected for display.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      buf_q[len_q[AW-1:0]] <= wr_char;
    end
  end

  assign seg3      = seg_q[0];
  assign seg2      = seg_q[1];
  assign seg1      = seg_q[2];
  assign seg0      = seg_q[3];
  assign len       = len_q;
  assign scrolling = (state_q == SCROLL);
  assign step      = step_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sseg_scroll_buffer.sv
module tb_sseg_scroll_buffer;

  localparam int DEPTH      = 8;
  localparam int SCROLL_DIV = 4;
  localparam int LW         = $clog2(DEPTH) + 1;
  localparam logic [4:0] BL = 5'h10;

  // Clock and reset
  logic          clk = 1'b0;
  logic          reset, clear, wr_valid, go;
  logic [4:0]    wr_char;
  logic          wr_ready, scrolling, step;
  logic [6:0]    seg3, seg2, seg1, seg0;
  logic [LW-1:0] len;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sseg_scroll_buffer #(.DEPTH(DEPTH), .SCROLL_DIV(SCROLL_DIV)) dut (
    .clk(clk), .reset(reset), .clear(clear), .wr_valid(wr_valid),
    .wr_char(wr_char), .wr_ready(wr_ready), .go(go),
    .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0),
    .len(len), .scrolling(scrolling), .step(step), .dbg_state(dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Segment table in gfedcba order, active low.
  function automatic logic [6:0] dec(input logic [4:0] c);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    if (c[4]) return 7'b1111111;
    return t[c[3:0]];
  endfunction

  function automatic logic [27:0] disp(input logic [4:0] a, b, c, d);
    return {dec(a), dec(b), dec(c), dec(d)};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 0; wr_valid = 0; go = 0; wr_char = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic write_char(input logic [4:0] c);
    wr_valid = 1; wr_char = c;
    tick();
    wr_valid = 0;
  endtask

  task automatic pulse_go();
    go = 1;
    tick();
    go = 0;
  endtask

  // Ticks until step is seen or the bound expires; n is the cycle count.
  task automatic wait_step(output int n, output logic seen);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = (step === 1'b1);
    end
  endtask

  task automatic test_reset();
    wr_valid = 1; wr_char = 5'h3; go = 1; clear = 1;
    reset = 1;
    tick();
    reset = 0;
    idle_inputs();
    checks++;
    if (len !== '0 || scrolling !== 1'b0 || step !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: len=%0d scrolling=%b step=%b state=%0d, required 0 0 0 0",
               len, scrolling, step, dbg_state);
    end
    checks++;
    if ({seg3, seg2, seg1, seg0} !== {4{7'b1111111}} || wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: segs=%h wr_ready=%b, required %h 1",
               {seg3, seg2, seg1, seg0}, wr_ready, {4{7'b1111111}});
    end
  endtask

  task automatic test_scroll_basic();
    logic [4:0] msg [5];
    int n;
    logic seen;
    msg = '{5'h1, 5'h2, 5'h3, 5'h4, 5'h5};
    do_reset();
    for (int i = 0; i < 5; i++) write_char(msg[i]);
    checks++;
    if (len !== LW'(5)) begin
      failures++;
      $display("FAIL basic_len: len=%0d, required 5", len);
    end
    pulse_go();
    tick();
    checks++;
    if ({seg3, seg2, seg1, seg0} !== disp(5'h1, 5'h2, 5'h3, 5'h4) || scrolling !== 1'b1) begin
      failures++;
      $display("FAIL basic_start: segs=%h scrolling=%b, required %h 1",
               {seg3, seg2, seg1, seg0}, scrolling, disp(5'h1, 5'h2, 5'h3, 5'h4));
    end
    // The first step is 4 clocks after the go edge. One of those clocks has
    // already been used to check the display.
    for (int s = 1; s <= 5; s++) begin
      wait_step(n, seen);
      checks++;
      if (!seen || n !== 3) begin
        failures++;
        $display("FAIL basic_step%0d: seen=%b after %0d cycles, required 1 after 3", s, seen, n);
      end
      tick();
      checks++;
      if ({seg3, seg2, seg1, seg0} !== disp(msg[s % 5], msg[(s + 1) % 5], msg[(s + 2) % 5], msg[(s + 3) % 5])
          || step !== 1'b0) begin
        failures++;
        $display("FAIL basic_disp%0d: segs=%h step=%b, required %h 0", s, {seg3, seg2, seg1, seg0}, step,
                 disp(msg[s % 5], msg[(s + 1) % 5], msg[(s + 2) % 5], msg[(s + 3) % 5]));
      end
    end
  endtask

  task automatic test_full();
    int acc = 0;
    int n;
    logic seen;
    do_reset();
    wr_valid = 1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_char = 5'(i);
      if (wr_ready) acc++;
      tick();
    end
    wr_valid = 0;
    checks++;
    if (acc !== DEPTH || len !== LW'(DEPTH) || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_accept: accepted=%0d len=%0d wr_ready=%b, required %0d %0d 0",
               acc, len, wr_ready, DEPTH, DEPTH);
    end
    pulse_go();
    tick();
    checks++;
    if ({seg3, seg2, seg1, seg0} !== disp(5'h0, 5'h1, 5'h2, 5'h3)) begin
      failures++;
      $display("FAIL full_disp0: segs=%h, required %h", {seg3, seg2, seg1, seg0}, disp(5'h0, 5'h1, 5'h2, 5'h3));
    end
    wait_step(n, seen);
    tick();
    checks++;
    if (!seen || {seg3, seg2, seg1, seg0} !== disp(5'h1, 5'h2, 5'h3, 5'h4)) begin
      failures++;
      $display("FAIL full_disp1: seen=%b segs=%h, required 1 %h", seen, {seg3, seg2, seg1, seg0},
               disp(5'h1, 5'h2, 5'h3, 5'h4));
    end
  endtask

  task automatic test_single();
    int n;
    logic seen;
    do_reset();
    write_char(5'h7);
    pulse_go();
    tick();
    checks++;
    if ({seg3, seg2, seg1, seg0} !== {4{7'b1111000}}) begin
      failures++;
      $display("FAIL single_start: segs=%h, required %h", {seg3, seg2, seg1, seg0}, {4{7'b1111000}});
    end
    for (int s = 0; s < 2; s++) begin
      wait_step(n, seen);
      tick();
      checks++;
      if (!seen || {seg3, seg2, seg1, seg0} !== {4{7'b1111000}}) begin
        failures++;
        $display("FAIL single_step%0d: seen=%b segs=%h, required 1 %h", s, seen,
                 {seg3, seg2, seg1, seg0}, {4{7'b1111000}});
      end
    end
  endtask

  task automatic test_go_with_write();
    int n;
    logic seen;
    do_reset();
    write_char(5'hC);
    write_char(5'hD);
    write_char(5'hE);
    go = 1; wr_valid = 1; wr_char = 5'hA;
    tick();
    idle_inputs();
    checks++;
    if (len !== LW'(4) || scrolling !== 1'b1) begin
      failures++;
      $display("FAIL gowr_state: len=%0d scrolling=%b, required 4 1", len, scrolling);
    end
    tick();
    checks++;
    if ({seg3, seg2, seg1, seg0} !== disp(5'hC, 5'hD, 5'hE, 5'hA)) begin
      failures++;
      $display("FAIL gowr_disp: segs=%h, required %h", {seg3, seg2, seg1, seg0}, disp(5'hC, 5'hD, 5'hE, 5'hA));
    end
    wait_step(n, seen);
    tick();
    checks++;
    if (!seen || {seg3, seg2, seg1, seg0} !== disp(5'hD, 5'hE, 5'hA, 5'hC)) begin
      failures++;
      $display("FAIL gowr_wrap: seen=%b segs=%h, required 1 %h", seen, {seg3, seg2, seg1, seg0},
               disp(5'hD, 5'hE, 5'hA, 5'hC));
    end
  endtask

  task automatic test_clear();
    // Continues from the SCROLL state left by the previous test.
    clear = 1; go = 1;
    tick();
    idle_inputs();
    checks++;
    if (dbg_state !== 2'd0 || len !== '0 || scrolling !== 1'b0 || wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_state: state=%0d len=%0d scrolling=%b wr_ready=%b, required 0 0 0 1",
               dbg_state, len, scrolling, wr_ready);
    end
    tick();
    checks++;
    if ({seg3, seg2, seg1, seg0} !== {4{7'b1111111}}) begin
      failures++;
      $display("FAIL clear_blank: segs=%h, required %h", {seg3, seg2, seg1, seg0}, {4{7'b1111111}});
    end
    pulse_go();
    checks++;
    if (scrolling !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL idle_go: scrolling=%b state=%0d, required 0 0", scrolling, dbg_state);
    end
    // Older entries still sit in the buffer, but only the new one may show.
    write_char(5'h3);
    tick();
    checks++;
    if (len !== LW'(1) || {seg3, seg2, seg1, seg0} !== disp(5'h3, BL, BL, BL)) begin
      failures++;
      $display("FAIL clear_reload: len=%0d segs=%h, required 1 %h", len, {seg3, seg2, seg1, seg0},
               disp(5'h3, BL, BL, BL));
    end
  endtask

  task automatic test_reset_mid_scroll();
    do_reset();
    for (int i = 1; i <= 4; i++) write_char(5'(i));
    pulse_go();
    // Three more edges bring the prescaler to its last count, so the next
    // edge would step.
    tick(); tick(); tick();
    reset = 1; go = 1; wr_valid = 1; wr_char = 5'h9; clear = 1;
    tick();
    reset = 0;
    idle_inputs();
    checks++;
    if (step !== 1'b0 || scrolling !== 1'b0 || len !== '0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL rst_mid_state: step=%b scrolling=%b len=%0d state=%0d, required 0 0 0 0",
               step, scrolling, len, dbg_state);
    end
    checks++;
    if ({seg3, seg2, seg1, seg0} !== {4{7'b1111111}} || wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_out: segs=%h wr_ready=%b, required %h 1",
               {seg3, seg2, seg1, seg0}, wr_ready, {4{7'b1111111}});
    end
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    tick();
    test_reset();
    test_scroll_basic();
    test_full();
    test_single();
    test_go_with_write();
    test_clear();
    test_reset_mid_scroll();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sseg_scroll_buffer.md
SSEG_SCROLL_BUFFER -- requirements
Module: sseg_scroll_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, the message buffer capacity in characters (power of two, 4..32).
REQ-002 The block SHALL have parameter SCROLL_DIV, default 50_000_000, the clock cycles per scroll step (>=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clear  input  1  single-cycle request to empty the buffer and return to IDLE.
REQ-006 wr_valid  input  1  character write request.
REQ-007 wr_char  input  5  character: bit4=1 blank, else bits[3:0] hex digit.
REQ-008 wr_ready  output  1  character accepted when wr_valid and wr_ready are both high on a rising edge.
REQ-009 go  input  1  single-cycle request to start scrolling.
REQ-010 seg3, seg2, seg1, seg0  output  7 each  registered active-low patterns, bit0=a..bit6=g; seg3 is the leftmost digit (drives the display mux's digit-3 input), seg0 the rightmost.
REQ-011 len  output  log2(DEPTH)+1  number of stored characters.
REQ-012 scrolling  output  1  high in SCROLL state.
REQ-013 step  output  1  one-cycle pulse on each scroll advance.

Function
REQ-014 States SHALL be IDLE, LOAD and SCROLL, with no other reachable encoding.
REQ-015 In IDLE: wr_ready=1; an accepted write stores at index 0, len becomes 1, and the next state is LOAD.
REQ-016 In LOAD: wr_ready=(len<DEPTH); an accepted write stores at index len and len increments; writes while len==DEPTH are not accepted.
REQ-017 go in LOAD SHALL move to SCROLL with pos=0 and the prescaler at 0; go in IDLE or SCROLL SHALL be ignored.
REQ-018 go and an accepted write in the same LOAD cycle: the write SHALL be stored and counted, then SCROLL is entered.
REQ-019 In SCROLL: wr_ready=0; the prescaler SHALL count 0..SCROLL_DIV-1 and wrap.
REQ-020 On each prescaler wrap, pos SHALL advance to pos+1, or to 0 if pos+1==len, and step SHALL pulse in that same cycle.
REQ-021 clear SHALL have priority over go and writes in every state: next state IDLE, len=0, pos=0, prescaler=0, no write stored.
REQ-022 Display in SCROLL: digit k (k=0 for seg3 through k=3 for seg0) SHALL show char[(pos+k) mod len], so that with len<4 the characters repeat.
REQ-023 Display in LOAD: digit k SHALL show char[k] if k<len, else blank; display in IDLE SHALL be all blank (7'b1111111).
REQ-024 The seg outputs SHALL be registered and reflect state, pos and buffer contents with exactly 1 cycle of latency.
REQ-025 Hex decode SHALL be (gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110; blank=1111111.
REQ-026 Buffer contents SHALL persist through clear (only len resets); unread entries SHALL never be displayed.

Reset
REQ-027 On reset high at a clock edge: state=IDLE, len=0, pos=0, prescaler=0, step=0, scrolling=0, all seg outputs=7'b1111111, wr_ready=1 on the following cycle.
REQ-028 Reset SHALL override clear, go and writes, including when asserted mid-SCROLL.

Verification
REQ-029 Reset, then write 1,2,3,4,5, then go (SCROLL_DIV=4) -> seg3..seg0 show 1234; after 4 cycles step pulses and the display shows 2345; successive steps show 3451, 4512, 5123, then 1234 again.
REQ-030 Write DEPTH+2 characters back-to-back with wr_valid held high -> exactly DEPTH accepted, wr_ready=0 with len=DEPTH, extra characters not stored.
REQ-031 Write only 7, then go -> all four digits show 1111000 and remain so across steps.
REQ-032 In LOAD with len=3, assert go and wr_valid (char A) in the same cycle -> len=4, SCROLL entered, display 0..3 shows the characters with A at seg0.
REQ-033 Assert clear mid-SCROLL together with go -> IDLE next cycle, len=0, scrolling=0, blank display one cycle later, wr_ready=1.
REQ-034 Assert reset mid-SCROLL while a step is due -> no step pulse; all outputs equal the REQ-027 values on the next cycle.
